// File: rtl/xfer_gate_pkg.sv
// Shared types and constants for the service-gate transfer sequencer:
// FSM states, requester ids, read-source codes and write-destination bit indices.
package xfer_gate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RT,
        ST_WT,
        ST_CT
    } xfer_state_t;

    typedef enum logic {
        REQ_SEQ = 1'b0,
        REQ_CNT = 1'b1
    } req_id_t;

    localparam logic [2:0] RSRC_NONE = 3'd0;
    localparam logic [2:0] RSRC_A    = 3'd1;
    localparam logic [2:0] RSRC_L    = 3'd2;
    localparam logic [2:0] RSRC_Q    = 3'd3;
    localparam logic [2:0] RSRC_Z    = 3'd4;
    localparam logic [2:0] RSRC_G    = 3'd5;
    localparam logic [2:0] RSRC_B    = 3'd6;
    localparam logic [2:0] RSRC_U    = 3'd7;

    localparam int WDST_A = 0;
    localparam int WDST_L = 1;
    localparam int WDST_Q = 2;
    localparam int WDST_Z = 3;
    localparam int WDST_G = 4;
    localparam int WDST_B = 5;
    localparam int WDST_S = 6;
    localparam int WDST_U = 7;

    // Code k pulls read-select bit k-1 low; code 0 selects nothing.
    function automatic logic [6:0] rsel_decode(input logic [2:0] code);
        logic [6:0] sel;
        sel = 7'h7F;
        if (code != RSRC_NONE) begin
            sel[code - 3'd1] = 1'b0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/xfer_arbiter.sv
// Two-way fixed-priority arbiter (CNT first) with a burst counter that
// hands the gate to SEQ after CNT_BURST consecutive CNT grants.
module xfer_arbiter
    import xfer_gate_pkg::*;
#(
    parameter int CNT_BURST = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    window,
    input  logic    seq_valid,
    input  logic    cnt_valid,
    output logic    seq_ready,
    output logic    cnt_ready,
    output logic    grant,
    output req_id_t grant_id
);

    localparam int BW = $clog2(CNT_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(CNT_BURST);

    logic [BW-1:0] burst_cnt;
    logic          seq_forced;

    always_comb begin
        seq_forced = seq_valid && (burst_cnt == BURST_MAX);
        cnt_ready  = window && cnt_valid && !seq_forced;
        seq_ready  = window && seq_valid && !cnt_ready;
        grant      = seq_ready || cnt_ready;
        grant_id   = cnt_ready ? REQ_CNT : REQ_SEQ;
    end

    // Only a pending SEQ request keeps the burst count alive across windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (window) begin
            if (!seq_valid || seq_ready) begin
                burst_cnt <= '0;
            end else if (cnt_ready) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xfer_gate_sequencer.sv
// Register-transfer sequencer for the service-gate stage: arbitrates SEQ/CNT
// and drives registered RT/WT/CT strobes plus read/write selects per transfer.
module xfer_gate_sequencer
    import xfer_gate_pkg::*;
#(
    parameter int CNT_BURST = 2,
    parameter int WT_CYCLES = 1
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       SEQ_VALID,
    output logic       SEQ_READY,
    input  logic [2:0] SEQ_RSRC,
    input  logic [7:0] SEQ_WDST,
    input  logic       CNT_VALID,
    output logic       CNT_READY,
    input  logic [2:0] CNT_RSRC,
    input  logic [7:0] CNT_WDST,
    input  logic       HOLD,
    output logic       RT_n,
    output logic       WT_n,
    output logic       CT_n,
    output logic [6:0] RSEL_n,
    output logic [7:0] WSEL_n,
    output logic       DONE,
    output logic       DONE_ID,
    output logic       BUSY
);

    localparam logic [1:0] WT_LAST = 2'(WT_CYCLES - 1);

    xfer_state_t state;
    xfer_state_t state_next;
    logic [1:0]  phase;
    logic [1:0]  phase_next;
    logic [2:0]  rsrc_q;
    logic [7:0]  wdst_q;
    req_id_t     id_q;
    logic        window;
    logic        grant;
    req_id_t     grant_id;

    assign window = !SIM_RST && ((state == ST_IDLE) || (state == ST_CT));
    assign BUSY   = (state != ST_IDLE);

    xfer_arbiter #(
        .CNT_BURST (CNT_BURST)
    ) u_arbiter (
        .clk       (SIM_CLK),
        .rst       (SIM_RST),
        .window    (window),
        .seq_valid (SEQ_VALID),
        .cnt_valid (CNT_VALID),
        .seq_ready (SEQ_READY),
        .cnt_ready (CNT_READY),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_next = state;
        phase_next = phase;
        case (state)
            ST_IDLE, ST_CT: begin
                state_next = grant ? ST_SETUP : ST_IDLE;
                phase_next = 2'd0;
            end
            ST_SETUP: begin
                if (!HOLD) begin
                    state_next = ST_RT;
                end
            end
            ST_RT: begin
                state_next = ST_WT;
                phase_next = 2'd0;
            end
            ST_WT: begin
                if (phase == WT_LAST) begin
                    state_next = ST_CT;
                end else begin
                    phase_next = phase + 2'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = 2'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every strobe and select is a
    // flop that changes only at phase boundaries.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state   <= ST_IDLE;
            phase   <= 2'd0;
            rsrc_q  <= RSRC_NONE;
            wdst_q  <= 8'h00;
            id_q    <= REQ_SEQ;
            RT_n    <= 1'b1;
            WT_n    <= 1'b1;
            CT_n    <= 1'b1;
            RSEL_n  <= 7'h7F;
            WSEL_n  <= 8'hFF;
            DONE    <= 1'b0;
            DONE_ID <= 1'b0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            if (grant) begin
                rsrc_q <= (grant_id == REQ_CNT) ? CNT_RSRC : SEQ_RSRC;
                wdst_q <= (grant_id == REQ_CNT) ? CNT_WDST : SEQ_WDST;
                id_q   <= grant_id;
            end
            RT_n    <= !((state_next == ST_RT) || (state_next == ST_WT));
            WT_n    <= !(state_next == ST_WT);
            CT_n    <= !(state_next == ST_CT);
            RSEL_n  <= ((state_next == ST_RT) || (state_next == ST_WT)) ? rsel_decode(rsrc_q) : 7'h7F;
            WSEL_n  <= ((state_next == ST_WT) || (state_next == ST_CT)) ? ~wdst_q : 8'hFF;
            DONE    <= (state_next == ST_CT);
            DONE_ID <= (state_next == ST_CT) && (id_q == REQ_CNT);
        end
    end

endmodule

// File: doc/xfer_gate_sequencer.md
# xfer_gate_sequencer

Sequences register-transfer cycles for the service-gate stage. Two requesters share the gate network: the instruction sequencer (SEQ) and the counter-cell increment unit (CNT). For each granted transfer the block drives the active-low read-select, write-select and RT/WT/CT timing strobes that the service gates combine into RxG_n/WxG_n/CxG outputs. Arbitration is fixed-priority with a starvation bound.

## Interface
Parameters:
- CNT_BURST, 2: maximum consecutive CNT grants while SEQ_VALID is pending.
- WT_CYCLES, 1: length of the WT phase in clocks (1..4).

Ports:
- SIM_CLK  in  1  clock.
- SIM_RST  in  1  reset, synchronous, active-high.
- SEQ_VALID  in  1  SEQ transfer request.
- SEQ_READY  out  1  SEQ request accepted this cycle.
- SEQ_RSRC  in  3  SEQ read-source code (0 = no read).
- SEQ_WDST  in  8  SEQ write-destination mask (any bits).
- CNT_VALID, CNT_READY, CNT_RSRC, CNT_WDST: same as the SEQ ports, for CNT.
- HOLD  in  1  inhibit; stalls a transfer before its RT phase.
- RT_n  out  1  read-timing strobe, active-low.
- WT_n  out  1  write-timing strobe, active-low.
- CT_n  out  1  clear-timing strobe, active-low.
- RSEL_n  out  7  one-cold read select; code k drives bit k-1.
- WSEL_n  out  8  active-low write selects, equal to ~WDST.
- DONE  out  1  high during the CT cycle of a transfer.
- DONE_ID  out  1  requester of the finishing transfer (0 = SEQ, 1 = CNT).
- BUSY  out  1  state is not IDLE.

## Operation
- States: IDLE, SETUP, RT, WT, CT.
- Grant window: state is IDLE or CT. In the window, READY is combinational from both VALIDs; at most one READY is high.
- Priority: CNT wins, unless the burst counter equals CNT_BURST and SEQ_VALID=1, in which case SEQ wins.
- Burst counter:
  - increments on each CNT grant;
  - clears on each SEQ grant, and whenever SEQ_VALID=0 in a grant window.
- On VALID&READY: capture RSRC, WDST and the requester id, then go to SETUP on the next cycle.
- If the window closes with no grant: go to IDLE.
- SETUP: all strobes and selects inactive. HOLD=1 stays in SETUP; HOLD=0 goes to RT.
- RT: RT_n=0; RSEL_n asserted for a nonzero code.
- WT: RT_n=0 and WT_n=0; RSEL_n held; WSEL_n asserted. Lasts WT_CYCLES clocks, counted by a phase counter.
- CT: CT_n=0; WSEL_n held; RSEL_n released; DONE=1 with DONE_ID.
- HOLD is ignored in RT, WT and CT: a started transfer always completes.
- RSRC=0 with WDST=0 runs as a null transfer. All strobes pulse, no selects are asserted, and DONE is reported.
- Reset values: RT_n=WT_n=CT_n=1, RSEL_n=7'h7F, WSEL_n=8'hFF, DONE=0, DONE_ID=0, BUSY=0, READY=0, burst counter=0, state IDLE.
- SIM_RST mid-transfer: all outputs return to reset values on the next edge. The aborted transfer gets no DONE.

## Timing
- All strobe and select outputs are registered and glitch-free, so they never change within a phase.
- Latency from accepting edge to RT_n low: 1 clock (SETUP) + HOLD cycles.
- A transfer occupies 3 + WT_CYCLES clocks. Back-to-back grants give CT → SETUP with no IDLE between.
- RSEL_n and WSEL_n are never asserted while CT_n=0 and RT_n=0 at the same time. Phases are disjoint.
- A request held with VALID=1 and changing payload before READY is illegal. The bench flags it as an assertion.

## Structure
- Shared package `xfer_gate_pkg` holds:
  - the state enum;
  - RSRC code constants (RSRC_NONE, RSRC_A, RSRC_L, RSRC_Q, RSRC_Z, RSRC_G, RSRC_B, RSRC_U = 0..7);
  - WDST bit-index constants;
  - the requester id enum.
- One sub-module, `xfer_arbiter`: two-way priority plus burst counter. It outputs the grant and the id.
- The FSM, phase counter and output registers live in the top level.

## Test plan
- Single SEQ transfer, RSRC=1, WDST=8'h04, WT_CYCLES=1:
  - SETUP, RT, WT, CT;
  - RSEL_n=7'h7E in RT and WT; WSEL_n=8'hFB in WT and CT;
  - DONE=1 with DONE_ID=0 on the 4th clock after accept.
- SEQ and CNT both always valid, CNT_BURST=2 → grant order CNT, CNT, SEQ, CNT, CNT, SEQ. Back-to-back with no IDLE cycles.
- HOLD=1 for 3 cycles after accept → stays in SETUP for 4 clocks, then RT. HOLD=1 raised during WT does not stretch it.
- WT_CYCLES=3, RSRC=0, WDST=0 → WT_n low for exactly 3 clocks; RSEL_n/WSEL_n never asserted; DONE pulses once.
- SIM_RST asserted in the WT phase → next edge: all strobes high, selects all-ones, BUSY=0, no DONE; a new request is accepted in the following cycle.
- CNT_VALID only, SEQ_VALID=0 → unlimited CNT grants, with the burst counter clearing each window.
